// File: rtl/dec_key_debounce.sv
// Ten-key keypad front-end: 2-flop synchroniser, debounce FSM, multi-key rejection.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module dec_key_debounce #(
  parameter int DEB_CYCLES    = 20000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys,
  output logic [9:0] dec,
  output logic       valid,
  output logic       key_down,
  output logic       err
);

  localparam int CNT_MAX = (DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [9:0]      sync1_r, ks_r;
  logic [9:0]      cand_r, cand_s;
  logic [9:0]      dec_s;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic            valid_s, err_s, key_down_s;
  logic            multi_s, onehot_s, deb_done_s;

  function automatic logic is_multi(input logic [9:0] v);
    return |(v & (v - 10'd1));
  endfunction

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && !is_multi(v);
  endfunction

  assign multi_s    = is_multi(ks_r);
  assign onehot_s   = is_onehot(ks_r);
  assign deb_done_s = (cnt_r == CW'(DEB_CYCLES - 1));
  // Saturating increment so the counter can never wrap back into a match.
  assign cnt_inc_s  = (cnt_r == CW'(CNT_MAX)) ? cnt_r : cnt_r + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 10'd0;
      ks_r    <= 10'd0;
    end else begin
      sync1_r <= keys;
      ks_r    <= sync1_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (multi_s) begin
          state_s = RELEASE;
        end else if (onehot_s) begin
          state_s = DEBOUNCE;
        end else begin
          state_s = IDLE;
        end
      end
      DEBOUNCE: begin
        if (multi_s) begin
          state_s = RELEASE;
        end else if (ks_r == cand_r) begin
          state_s = deb_done_s ? HELD : DEBOUNCE;
        end else begin
          state_s = IDLE;
        end
      end
      HELD: begin
        if (ks_r != dec) begin
          state_s = RELEASE;
        end else begin
          state_s = HELD;
        end
      end
      RELEASE: begin
        if ((ks_r == 10'd0) && deb_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  always_comb begin
    cnt_s   = cnt_r;
    cand_s  = cand_r;
    dec_s   = dec;
    valid_s = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (multi_s) begin
          err_s = 1'b1;
          cnt_s = CW'(0);
        end else if (onehot_s) begin
          cand_s = ks_r;
          cnt_s  = CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      DEBOUNCE: begin
        if (multi_s) begin
          err_s = 1'b1;
          cnt_s = CW'(0);
        end else if ((ks_r == cand_r) && deb_done_s) begin
          dec_s   = cand_r;
          valid_s = 1'b1;
          cnt_s   = CW'(0);
        end else if (ks_r == cand_r) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = cnt_r;
        end
      end
      HELD: begin
        if (ks_r != dec) begin
          cnt_s = CW'(0);
`ifdef KEY_REPEAT_EN
        end else if (cnt_r == CW'(REPEAT_CYCLES - 1)) begin
          valid_s = 1'b1;
          cnt_s   = CW'(0);
        end else begin
          cnt_s = cnt_inc_s;
        end
`else
        end else begin
          cnt_s = cnt_r;
        end
`endif
      end
      RELEASE: begin
        // Any nonzero sample restarts the all-keys-up qualification.
        if ((ks_r == 10'd0) && deb_done_s) begin
          cnt_s = CW'(0);
        end else if (ks_r == 10'd0) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = CW'(0);
        end
      end
      default: begin
        cnt_s = CW'(0);
      end
    endcase
    key_down_s = (state_s == HELD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= CW'(0);
      cand_r   <= 10'd0;
      dec      <= 10'd0;
      valid    <= 1'b0;
      err      <= 1'b0;
      key_down <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      cand_r   <= cand_s;
      dec      <= dec_s;
      valid    <= valid_s;
      err      <= err_s;
      key_down <= key_down_s;
    end
  end

endmodule

// File: tb/tb_dec_key_debounce.sv
// Directed bench for dec_key_debounce (DEB_CYCLES=4, REPEAT_CYCLES=8); expected
// dec codes are queued at stimulus time and popped on every valid pulse.
module tb_dec_key_debounce;

  localparam int DEB = 4;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keys;
  logic [9:0] dec;
  logic       valid;
  logic       key_down;
  logic       err;

  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  dec_key_debounce #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk      (clk),
    .rst      (rst),
    .keys     (keys),
    .dec      (dec),
    .valid    (valid),
    .key_down (key_down),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dec"}, 32'(dec), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_key_down"}, 32'(key_down), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic press_accept(input logic [9:0] k);
    exp_q.push_back(k);
    keys = k;
    tick(6);
    check("acc_valid", 32'(valid), 32'd1);
    check("acc_dec", 32'(dec), 32'(k));
    check("acc_key_down", 32'(key_down), 32'd1);
  endtask

  task automatic release_rearm();
    keys = 10'd0;
    tick(10);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_pulses++;
      if (valid) begin
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_dec", 32'(dec), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    keys = 10'd0;
    #1;
    check_all_zero("reset");
    tick(2);
    check_all_zero("reset_hold");
    rst = 1'b0;
    tick(2);

    // Key 7 held about 20 cycles.
    exp_q.push_back(10'h080);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(10'h080);
`endif
    keys = 10'h080;
    tick(5);
    check("k7_early_valid", 32'(valid), 32'd0);
    tick(1);
    check("k7_valid", 32'(valid), 32'd1);
    check("k7_dec", 32'(dec), 32'h080);
    check("k7_key_down", 32'(key_down), 32'd1);
    tick(1);
    check("k7_valid_one_cycle", 32'(valid), 32'd0);
    check("k7_still_down", 32'(key_down), 32'd1);
    tick(12);
    keys = 10'd0;
    tick(2);
    check("k7_down_before_release", 32'(key_down), 32'd1);
    tick(1);
    check("k7_released", 32'(key_down), 32'd0);
    check("k7_dec_kept", 32'(dec), 32'h080);
    tick(8);
    check("k7_sb_drained", 32'(exp_q.size()), 32'd0);

    // Key 3 bouncing: never stable for four samples.
    keys = 10'h008; tick(2);
    keys = 10'h000; tick(1);
    keys = 10'h008; tick(2);
    keys = 10'h000; tick(10);
    check("bounce_dec_kept", 32'(dec), 32'h080);
    check("bounce_key_down", 32'(key_down), 32'd0);
    check("bounce_no_valid", 32'(exp_q.size()), 32'd0);

    // Keys 2 and 5 together: rejected with a single err pulse.
    keys = 10'h024;
    tick(3);
    check("multi_err", 32'(err), 32'd1);
    check("multi_no_valid", 32'(valid), 32'd0);
    tick(1);
    check("multi_err_one_cycle", 32'(err), 32'd0);
    tick(2);
    keys = 10'd0;
    tick(8);
    check("multi_err_count", 32'(err_pulses), 32'd1);
    check("multi_dec_kept", 32'(dec), 32'h080);
    press_accept(10'h001);
    release_rearm();

    // Key 9 accepted, then key 1 added while held.
    press_accept(10'h200);
    keys = 10'h202;
    tick(2);
    check("k9_still_down", 32'(key_down), 32'd1);
    tick(1);
    check("k9_left_held", 32'(key_down), 32'd0);
    check("k9_no_err", 32'(err), 32'd0);
    keys = 10'h002;
    tick(10);
    check("k1_blocked_dec", 32'(dec), 32'h200);
    keys = 10'd0;
    tick(2);
    keys = 10'h002;
    tick(10);
    check("k1_short_gap_dec", 32'(dec), 32'h200);
    check("k1_short_gap_sb", 32'(exp_q.size()), 32'd0);
    keys = 10'd0;
    tick(10);
    press_accept(10'h002);
    release_rearm();

    // Reset mid-DEBOUNCE with the key still held.
    keys = 10'h040;
    tick(4);
    rst = 1'b1;
    #1;
    check_all_zero("rst_deb");
    tick(2);
    rst = 1'b0;
    press_accept(10'h040);

    // Reset mid-HELD with the key still held.
    tick(3);
    check("k6_held", 32'(key_down), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_held");
    tick(2);
    rst = 1'b0;
    press_accept(10'h040);
    release_rearm();

`ifdef KEY_REPEAT_EN
    // Key 4 held for 30 cycles: acceptance plus three repeats.
    repeat (3) exp_q.push_back(10'h010);
    press_accept(10'h010);
    for (int r = 1; r <= 3; r++) begin
      tick(REP - 1);
      check("rep_gap_quiet", 32'(valid), 32'd0);
      tick(1);
      check("rep_valid", 32'(valid), 32'd1);
      check("rep_dec", 32'(dec), 32'h010);
    end
    release_rearm();
    check("rep_dec_after", 32'(dec), 32'h010);
`endif

    check("total_err_pulses", 32'(err_pulses), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_key_debounce.md
# dec_key_debounce

Front-end for the ten-key decimal keypad. It synchronises and debounces the raw key lines and rejects multi-key presses. It then presents one clean one-hot `dec[9:0]` code plus a one-cycle `valid` strobe per accepted press. `dec` feeds the `dec` input of the `dec_to_bcd` encoder directly, and `valid` tells downstream logic when the resulting BCD digit is new.

## Interface
- `DEB_CYCLES`, 20000 — consecutive stable synchronised samples required to accept a press or confirm a release. Minimum 2. 20000 = 2 ms at 10 MHz.
- `REPEAT_CYCLES`, 5000000 — auto-repeat period in cycles while a key is held. Used only with `KEY_REPEAT_EN`. Minimum 2.
- `clk`  in  1 — system clock, rising edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `keys`  in  10 — raw key lines, active-high, asynchronous to `clk`. Bit n = digit n.
- `dec`  out  10 — registered one-hot code of the last accepted key. All zero until the first acceptance.
- `valid`  out  1 — one-cycle pulse when `dec` has just been (re)issued.
- `key_down`  out  1 — high while the accepted key is still held (state HELD).
- `err`  out  1 — one-cycle pulse when a multi-key press is rejected.

## Operation
- `keys` passes through a 2-flop synchroniser, giving `ks`. All decisions below use `ks`.
- Counter `cnt` width is `$clog2(max(DEB_CYCLES,REPEAT_CYCLES)+1)`. It saturates and never wraps.
- The FSM has four states: IDLE, DEBOUNCE, HELD, RELEASE.
- **IDLE:**
  - `ks` exactly one-hot: capture the candidate, set `cnt<=1`, go to DEBOUNCE.
  - `ks` has ≥2 bits set: pulse `err`, set `cnt<=0`, go to RELEASE.
  - `ks` is zero: stay in IDLE.
- **DEBOUNCE:**
  - `ks==candidate` and `cnt==DEB_CYCLES-1`: `dec<=candidate`, `valid<=1`, `cnt<=0`, go to HELD.
  - `ks==candidate` otherwise: `cnt++`.
  - `ks` has ≥2 bits set: pulse `err`, go to RELEASE.
  - `ks` is zero or a different single key: go to IDLE. No `err`, and `dec` is unchanged.
- **HELD:**
  - `ks!=dec` (released, changed, or an extra key pressed): `cnt<=0`, go to RELEASE. No `err`.
  - Otherwise stay in HELD. See Configuration for repeat behaviour.
- **RELEASE:**
  - `ks==0`: `cnt++`. When `cnt==DEB_CYCLES-1` with `ks==0`, go to IDLE.
  - Any nonzero `ks`: `cnt<=0`, stay in RELEASE.
- `dec` holds the last accepted key through RELEASE and IDLE. It changes only on acceptance.
- Simultaneous events: multi-key detection takes priority over the match/mismatch checks in IDLE and DEBOUNCE.

## Timing
- Reset values: state IDLE, synchroniser 0, `cnt` 0, `dec`=0, `valid`=0, `key_down`=0, `err`=0. Reset takes effect immediately and asynchronously, including mid-debounce or mid-hold.
- Acceptance latency: take edge 1 as the first edge that samples the raw key high. With the key stable, `valid` is high in the cycle after edge 2+`DEB_CYCLES`, and `dec` updates on that same edge.
- `valid`, `err`: high for exactly one cycle.
- `key_down`: high from the acceptance edge until the edge that leaves HELD.
- Re-arm: the next press needs `DEB_CYCLES` consecutive zero samples in RELEASE first.
- Key held through reset: after reset is released, the key is debounced and accepted again as a new press.
- Bounce shorter than `DEB_CYCLES` samples in DEBOUNCE: no `valid`.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In HELD, `cnt` counts from 0.
  - When `cnt==REPEAT_CYCLES-1`, `valid` pulses again with `dec` unchanged and `cnt<=0`. The first repeat comes `REPEAT_CYCLES` cycles after acceptance.
- `KEY_REPEAT_EN` undefined:
  - Exactly one `valid` per press.
  - The repeat logic is absent and `cnt` idles in HELD.

## Test plan
All scenarios use `DEB_CYCLES=4`, `REPEAT_CYCLES=8`.
- Key 7 high from edge 1, held 20 cycles → `valid` pulses once after edge 6, `dec`=10'b0010000000, `key_down`=1. Release → `key_down`=0 and `dec` is unchanged.
- Key 3 bouncing (high 2 cycles, low 1, high 2, low) → no `valid`, `dec` stays at its previous value, FSM back in IDLE.
- Keys 2 and 5 pressed together → one `err` pulse, no `valid`. After both are released and 4 zero samples pass, key 0 press → `dec`=10'b0000000001 with `valid`.
- Key 9 accepted, then key 1 added while held → leave HELD without `err`. Key 1 alone is not accepted until all keys have read zero for 4 samples.
- `rst` asserted mid-DEBOUNCE and mid-HELD → all outputs 0 immediately. Key still held after `rst` deasserts → re-accepted 2+4 cycles later.
- `KEY_REPEAT_EN` defined, key 4 held 30 cycles → `valid` pulses at acceptance, then at acceptance+8, +16 and +24, with `dec`=10'b0000010000 throughout.
